// File: rtl/ita_scan_seq.sv
// ita_scan_seq: dwell-timed scan sequencer driving the 6-bit ita frame index with tick/wrap/blank strobes.
// Define ITA_SCAN_PINGPONG_EN to scan up and back down (triangle) instead of the default sawtooth.
module ita_scan_seq #(
    parameter int DWELL_W   = 24,
    parameter int BLANK_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               step,
    input  logic               restart,
    input  logic [5:0]         last_idx,
    input  logic [DWELL_W-1:0] dwell,
    output logic [5:0]         nsel,
    output logic               tick,
    output logic               wrap,
    output logic               blank
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int            BW         = (BLANK_CYC < 2) ? 1 : $clog2(BLANK_CYC);
    localparam logic [BW-1:0] BLEFT_INIT = (BLANK_CYC > 1) ? BW'(BLANK_CYC - 1) : '0;
    localparam logic          BLANK_EN   = (BLANK_CYC > 0);

    state_t             state, state_n;
    logic [DWELL_W-1:0] cnt, cnt_n, dwell_last;
    logic [5:0]         nsel_n, next_idx;
    logic               tick_n, wrap_n, blank_n, advance;
    logic [BW-1:0]      bleft, bleft_n;
`ifdef ITA_SCAN_PINGPONG_EN
    logic               dir_up, dir_up_n, next_dir_up;
`endif

    // A dwell of 0 behaves like 1, so both match when cnt is 0.
    assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    always_comb begin
        next_idx = 6'd0;
`ifdef ITA_SCAN_PINGPONG_EN
        next_dir_up = 1'b1;
        if (dir_up) begin
            if (last_idx != 6'd0 && nsel < last_idx) begin
                next_idx    = nsel + 6'd1;
                next_dir_up = ((nsel + 6'd1) != last_idx);
            end
        end else if (nsel > 6'd1) begin
            next_idx    = nsel - 6'd1;
            next_dir_up = 1'b0;
        end
`else
        if (nsel < last_idx) begin
            next_idx = nsel + 6'd1;
        end
`endif
    end

    // Blank counts down from each advance; leaving RUN or restart clears it outright.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        nsel_n  = nsel;
        tick_n  = 1'b0;
        wrap_n  = 1'b0;
        blank_n = blank;
        bleft_n = bleft;
        advance = 1'b0;
`ifdef ITA_SCAN_PINGPONG_EN
        dir_up_n = dir_up;
`endif
        if (restart) begin
            state_n = enable ? RUN : IDLE;
            cnt_n   = '0;
            nsel_n  = 6'd0;
            blank_n = 1'b0;
            bleft_n = '0;
`ifdef ITA_SCAN_PINGPONG_EN
            dir_up_n = 1'b1;
`endif
        end else begin
            if (blank) begin
                if (bleft == '0) begin
                    blank_n = 1'b0;
                end else begin
                    bleft_n = bleft - BW'(1);
                end
            end
            case (state)
                IDLE: begin
                    cnt_n   = '0;
                    advance = step;
                    if (enable) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        blank_n = 1'b0;
                        bleft_n = '0;
                    end else if (cnt == dwell_last) begin
                        advance = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
            if (advance) begin
                nsel_n = next_idx;
                tick_n = 1'b1;
                wrap_n = (next_idx == 6'd0);
                if (BLANK_EN) begin
                    blank_n = 1'b1;
                    bleft_n = BLEFT_INIT;
                end
`ifdef ITA_SCAN_PINGPONG_EN
                dir_up_n = next_dir_up;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            nsel  <= 6'd0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
            blank <= 1'b0;
            bleft <= '0;
`ifdef ITA_SCAN_PINGPONG_EN
            dir_up <= 1'b1;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            nsel  <= nsel_n;
            tick  <= tick_n;
            wrap  <= wrap_n;
            blank <= blank_n;
            bleft <= bleft_n;
`ifdef ITA_SCAN_PINGPONG_EN
            dir_up <= dir_up_n;
`endif
        end
    end
endmodule
